// File: rtl/dtlb_pkg.sv
// Shared types and geometry constants for the dtlb and its fill/invalidate controller.
package dtlb_pkg;

  localparam int DTLB_SETS     = 16;
  localparam int DTLB_WAYS     = 8;
  localparam int DTLB_INIT_CYC = 16;
  localparam int DTLB_PORTS    = 6;
  localparam int DTLB_DATA_W   = 64;

  typedef enum logic [2:0] {
    RST_WAIT,
    IDLE,
    WREQ,
    WWAIT,
    FILL,
    INV_STEAL,
    INV_WR,
    INV_SWEEP
  } dtlb_fill_st_t;

endpackage

// File: rtl/dtlb_missq.sv
// Small circular miss queue with a per-probe page-pair match vector used for merging.
module dtlb_missq
  import dtlb_pkg::*;
#(
  parameter int VA_W   = 51,
  parameter int DEPTH  = 4,
  parameter int NPROBE = DTLB_PORTS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [VA_W-1:0]                push_addr_i,
  input  logic                           pop_i,
  input  logic [NPROBE-1:0][VA_W-1:0]    probe_addr_i,
  output logic [NPROBE-1:0]              match_o,
  output logic [VA_W-1:0]                head_addr_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [$clog2(DEPTH):0]         count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][VA_W-1:0]  addr_q;
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [PTR_W:0]              cnt_q;

  // The caller only pushes when not full or when a pop frees the head slot in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (pop_i) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      if (push_i) begin
        vld_q[wr_ptr_q]  <= 1'b1;
        addr_q[wr_ptr_q] <= push_addr_i;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      cnt_q <= cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end
  end

  // Entries cover an even/odd page pair, so bit 0 is ignored when matching.
  always_comb begin
    match_o = '0;
    for (int p = 0; p < NPROBE; p++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (vld_q[e] && (addr_q[e][VA_W-1:1] == probe_addr_i[p][VA_W-1:1])) begin
          match_o[p] = 1'b1;
        end
      end
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign count_o     = cnt_q;

endmodule

// File: rtl/dtlb_fill_ctl.sv
// dtlb fill/invalidate sequencer: merges port misses, issues one page walk at a time,
// writes results back with LRU replacement, and runs single or full invalidations.
module dtlb_fill_ctl
  import dtlb_pkg::*;
#(
  parameter int VA_W     = 51,
  parameter int DATA_W   = DTLB_DATA_W,
  parameter int MQ_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DTLB_PORTS-1:0]             miss_valid,
  input  logic [DTLB_PORTS-1:0][VA_W-1:0]   miss_addr,
  output logic [DTLB_PORTS-1:0]             miss_ack,
  output logic                              walk_req_valid,
  output logic [VA_W-1:0]                   walk_req_addr,
  input  logic                              walk_req_ready,
  input  logic                              walk_rsp_valid,
  input  logic                              walk_rsp_fault,
  input  logic [DATA_W-1:0]                 walk_rsp_data0,
  input  logic [DATA_W-1:0]                 walk_rsp_data1,
  input  logic [DATA_W-1:0]                 walk_rsp_data2,
  output logic [VA_W-1:0]                   tlb_write_addr,
  output logic [DATA_W-1:0]                 tlb_write_data0,
  output logic [DATA_W-1:0]                 tlb_write_data1,
  output logic [DATA_W-1:0]                 tlb_write_data2,
  output logic                              tlb_write_wen,
  output logic                              tlb_write_xstant,
  output logic                              tlb_write_invl,
  output logic                              tlb_force_way_en,
  output logic [2:0]                        tlb_force_way,
  output logic                              port0_steal,
  input  logic                              inv_valid,
  input  logic                              inv_all,
  input  logic [VA_W-1:0]                   inv_addr,
  output logic                              inv_ready,
  output logic                              fault_valid,
  output logic [VA_W-1:0]                   fault_addr,
  output dtlb_fill_st_t                     dbg_state,
  output logic [$clog2(MQ_DEPTH):0]         dbg_mq_count
);

  localparam int WAY_W = $clog2(DTLB_WAYS);
  localparam int CNT_W = $clog2(DTLB_SETS * DTLB_WAYS);

  // Handshakes: walk request transfers when walk_req_valid && walk_req_ready; an
  // invalidation transfers when inv_valid && inv_ready; miss_ack is the per-port ready.
  dtlb_fill_st_t      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               wreq_valid_q;
  logic [VA_W-1:0]    wreq_addr_q;
  logic [VA_W-1:0]    waddr_q;
  logic [DATA_W-1:0]  wdata0_q, wdata1_q, wdata2_q;
  logic               wen_q, xstant_q, invl_q, fwe_q, steal_q;
  logic [WAY_W-1:0]   fway_q;
  logic               fault_valid_q;
  logic [VA_W-1:0]    fault_addr_q;

  logic [DTLB_PORTS-1:0] mq_match;
  logic [DTLB_PORTS-1:0] alloc_oh;
  logic [DTLB_PORTS-1:0] pair_hit;
  logic                  alloc_any;
  logic [VA_W-1:0]       alloc_addr;
  logic [VA_W-1:0]       mq_head;
  logic [VA_W-1:0]       req_src;
  logic                  mq_empty, mq_full;
  logic                  intake_en, mq_push, mq_pop;

  assign intake_en = (state_q != RST_WAIT);
  assign mq_pop    = (state_q == FILL) ||
                     ((state_q == WWAIT) && walk_rsp_valid && walk_rsp_fault);

  // Lowest-index port that does not already merge with a queued entry gets the slot.
  always_comb begin
    alloc_oh   = '0;
    alloc_any  = 1'b0;
    alloc_addr = '0;
    for (int p = 0; p < DTLB_PORTS; p++) begin
      if (miss_valid[p] && !mq_match[p] && !alloc_any) begin
        alloc_oh[p] = 1'b1;
        alloc_any   = 1'b1;
        alloc_addr  = miss_addr[p];
      end
    end
  end

  always_comb begin
    pair_hit = '0;
    for (int p = 0; p < DTLB_PORTS; p++) begin
      pair_hit[p] = miss_valid[p] && (miss_addr[p][VA_W-1:1] == alloc_addr[VA_W-1:1]);
    end
  end

  assign mq_push  = intake_en && alloc_any && (!mq_full || mq_pop);
  assign miss_ack = intake_en ? ((miss_valid & mq_match) | (mq_push ? pair_hit : '0)) : '0;

  dtlb_missq #(
    .VA_W   (VA_W),
    .DEPTH  (MQ_DEPTH),
    .NPROBE (DTLB_PORTS)
  ) u_missq (
    .clk          (clk),
    .rst          (rst),
    .push_i       (mq_push),
    .push_addr_i  (alloc_addr),
    .pop_i        (mq_pop),
    .probe_addr_i (miss_addr),
    .match_o      (mq_match),
    .head_addr_o  (mq_head),
    .empty_o      (mq_empty),
    .full_o       (mq_full),
    .count_o      (dbg_mq_count)
  );

  assign req_src = mq_empty ? alloc_addr : mq_head;
  assign cnt_nxt = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RST_WAIT;
      cnt_q         <= '0;
      wreq_valid_q  <= 1'b0;
      wreq_addr_q   <= '0;
      waddr_q       <= '0;
      wdata0_q      <= '0;
      wdata1_q      <= '0;
      wdata2_q      <= '0;
      wen_q         <= 1'b0;
      xstant_q      <= 1'b0;
      invl_q        <= 1'b0;
      fwe_q         <= 1'b0;
      fway_q        <= '0;
      steal_q       <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      case (state_q)
        RST_WAIT: begin
          cnt_q <= cnt_nxt;
          if (cnt_q == CNT_W'(DTLB_INIT_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (inv_valid) begin
            if (inv_all) begin
              state_q  <= INV_SWEEP;
              cnt_q    <= '0;
              wen_q    <= 1'b1;
              xstant_q <= 1'b1;
              invl_q   <= 1'b1;
              fwe_q    <= 1'b1;
              fway_q   <= '0;
              waddr_q  <= '0;
            end else begin
              state_q <= INV_STEAL;
              steal_q <= 1'b1;
              waddr_q <= inv_addr;
            end
          end else if (!mq_empty || mq_push) begin
            state_q      <= WREQ;
            wreq_valid_q <= 1'b1;
            wreq_addr_q  <= {req_src[VA_W-1:1], 1'b0};
          end
        end
        WREQ: begin
          if (walk_req_ready) begin
            state_q      <= WWAIT;
            wreq_valid_q <= 1'b0;
            wreq_addr_q  <= '0;
          end
        end
        WWAIT: begin
          if (walk_rsp_valid) begin
            if (walk_rsp_fault) begin
              state_q       <= IDLE;
              fault_valid_q <= 1'b1;
              fault_addr_q  <= mq_head;
            end else begin
              state_q  <= FILL;
              wen_q    <= 1'b1;
              waddr_q  <= {mq_head[VA_W-1:1], 1'b0};
              wdata0_q <= walk_rsp_data0;
              wdata1_q <= walk_rsp_data1;
              wdata2_q <= walk_rsp_data2;
            end
          end
        end
        FILL: begin
          state_q  <= IDLE;
          wen_q    <= 1'b0;
          waddr_q  <= '0;
          wdata0_q <= '0;
          wdata1_q <= '0;
          wdata2_q <= '0;
        end
        INV_STEAL: begin
          // Address already sits on read port 0; the dtlb resolves the hitting way itself.
          state_q  <= INV_WR;
          wen_q    <= 1'b1;
          xstant_q <= 1'b1;
          invl_q   <= 1'b1;
        end
        INV_WR: begin
          state_q  <= IDLE;
          steal_q  <= 1'b0;
          wen_q    <= 1'b0;
          xstant_q <= 1'b0;
          invl_q   <= 1'b0;
          waddr_q  <= '0;
        end
        INV_SWEEP: begin
          if (cnt_q == CNT_W'(DTLB_SETS * DTLB_WAYS - 1)) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wen_q    <= 1'b0;
            xstant_q <= 1'b0;
            invl_q   <= 1'b0;
            fwe_q    <= 1'b0;
            fway_q   <= '0;
            waddr_q  <= '0;
          end else begin
            cnt_q   <= cnt_nxt;
            fway_q  <= cnt_nxt[WAY_W-1:0];
            waddr_q <= VA_W'(cnt_nxt[CNT_W-1:WAY_W]);
          end
        end
      endcase
    end
  end

  assign walk_req_valid   = wreq_valid_q;
  assign walk_req_addr    = wreq_addr_q;
  assign tlb_write_addr   = waddr_q;
  assign tlb_write_data0  = wdata0_q;
  assign tlb_write_data1  = wdata1_q;
  assign tlb_write_data2  = wdata2_q;
  assign tlb_write_wen    = wen_q;
  assign tlb_write_xstant = xstant_q;
  assign tlb_write_invl   = invl_q;
  assign tlb_force_way_en = fwe_q;
  assign tlb_force_way    = fway_q;
  assign port0_steal      = steal_q;
  assign inv_ready        = (state_q == IDLE);
  assign fault_valid      = fault_valid_q;
  assign fault_addr       = fault_addr_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_dtlb_fill_ctl.sv
// Directed bench for dtlb_fill_ctl: reset gating, merge/priority, full queue, fill, fault,
// full sweep and single invalidation, and reset in the middle of a walk.
module tb_dtlb_fill_ctl;
  import dtlb_pkg::*;

  localparam int VA_W     = 51;
  localparam int DATA_W   = 64;
  localparam int MQ_DEPTH = 4;

  logic                               clk = 1'b0;
  logic                               rst;
  logic [DTLB_PORTS-1:0]              miss_valid;
  logic [DTLB_PORTS-1:0][VA_W-1:0]    miss_addr;
  logic [DTLB_PORTS-1:0]              miss_ack;
  logic                               walk_req_valid;
  logic [VA_W-1:0]                    walk_req_addr;
  logic                               walk_req_ready;
  logic                               walk_rsp_valid;
  logic                               walk_rsp_fault;
  logic [DATA_W-1:0]                  walk_rsp_data0, walk_rsp_data1, walk_rsp_data2;
  logic [VA_W-1:0]                    tlb_write_addr;
  logic [DATA_W-1:0]                  tlb_write_data0, tlb_write_data1, tlb_write_data2;
  logic                               tlb_write_wen, tlb_write_xstant, tlb_write_invl;
  logic                               tlb_force_way_en;
  logic [2:0]                         tlb_force_way;
  logic                               port0_steal;
  logic                               inv_valid, inv_all;
  logic [VA_W-1:0]                    inv_addr;
  logic                               inv_ready;
  logic                               fault_valid;
  logic [VA_W-1:0]                    fault_addr;
  dtlb_fill_st_t                      dbg_state;
  logic [$clog2(MQ_DEPTH):0]          dbg_mq_count;

  int checks = 0;
  int errors = 0;
  logic [VA_W-1:0]   exp_q[$];
  logic [DATA_W-1:0] exp_data_q[$];

  dtlb_fill_ctl #(.VA_W(VA_W), .DATA_W(DATA_W), .MQ_DEPTH(MQ_DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_valid       (miss_valid),
    .miss_addr        (miss_addr),
    .miss_ack         (miss_ack),
    .walk_req_valid   (walk_req_valid),
    .walk_req_addr    (walk_req_addr),
    .walk_req_ready   (walk_req_ready),
    .walk_rsp_valid   (walk_rsp_valid),
    .walk_rsp_fault   (walk_rsp_fault),
    .walk_rsp_data0   (walk_rsp_data0),
    .walk_rsp_data1   (walk_rsp_data1),
    .walk_rsp_data2   (walk_rsp_data2),
    .tlb_write_addr   (tlb_write_addr),
    .tlb_write_data0  (tlb_write_data0),
    .tlb_write_data1  (tlb_write_data1),
    .tlb_write_data2  (tlb_write_data2),
    .tlb_write_wen    (tlb_write_wen),
    .tlb_write_xstant (tlb_write_xstant),
    .tlb_write_invl   (tlb_write_invl),
    .tlb_force_way_en (tlb_force_way_en),
    .tlb_force_way    (tlb_force_way),
    .port0_steal      (port0_steal),
    .inv_valid        (inv_valid),
    .inv_all          (inv_all),
    .inv_addr         (inv_addr),
    .inv_ready        (inv_ready),
    .fault_valid      (fault_valid),
    .fault_addr       (fault_addr),
    .dbg_state        (dbg_state),
    .dbg_mq_count     (dbg_mq_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_handshake();
    logic [VA_W-1:0] e;
    e = '1;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk("walk_req_hs_valid", 64'(walk_req_valid), 64'h1);
    chk("walk_req_hs_addr", 64'(walk_req_addr), 64'(e));
  endtask

  task automatic fill_check();
    logic [DATA_W-1:0] d0, d1, d2;
    d0 = '1; d1 = '1; d2 = '1;
    if (exp_data_q.size() >= 3) begin
      d0 = exp_data_q.pop_front();
      d1 = exp_data_q.pop_front();
      d2 = exp_data_q.pop_front();
    end
    chk("fill_data0", 64'(tlb_write_data0), 64'(d0));
    chk("fill_data1", 64'(tlb_write_data1), 64'(d1));
    chk("fill_data2", 64'(tlb_write_data2), 64'(d2));
  endtask

  initial begin
    rst            = 1'b1;
    miss_valid     = 6'b000001;
    miss_addr      = '0;
    miss_addr[0]   = 51'h1001;
    walk_req_ready = 1'b0;
    walk_rsp_valid = 1'b0;
    walk_rsp_fault = 1'b0;
    walk_rsp_data0 = '0;
    walk_rsp_data1 = '0;
    walk_rsp_data2 = '0;
    inv_valid      = 1'b0;
    inv_all        = 1'b0;
    inv_addr       = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(miss_ack), 64'h0);
    chk("rst_req_valid", 64'(walk_req_valid), 64'h0);
    chk("rst_wen", 64'(tlb_write_wen), 64'h0);
    chk("rst_inv_ready", 64'(inv_ready), 64'h0);
    chk("rst_fault", 64'(fault_valid), 64'h0);
    chk("rst_steal", 64'(port0_steal), 64'h0);
    chk("rst_count", 64'(dbg_mq_count), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(RST_WAIT));

    // Cycle 0 begins at deassertion; the init sweep occupies cycles 0..15.
    rst = 1'b0;
    for (int c = 0; c < DTLB_INIT_CYC; c++) begin
      #4;
      chk("gate_ack", 64'(miss_ack), 64'h0);
      tick();
    end

    // cycle 16
    #4;
    chk("first_ack", 64'(miss_ack), 64'h01);
    if (miss_ack[0]) exp_q.push_back(51'h1000);
    tick();

    // cycle 17: WREQ for 0x1000; ports 2/5 share a page pair, port 3 must wait
    miss_addr[2] = 51'h1234;
    miss_addr[3] = 51'h2000;
    miss_addr[5] = 51'h1235;
    miss_valid   = 6'b101100;
    #4;
    chk("req_valid_first", 64'(walk_req_valid), 64'h1);
    chk("req_addr_first", 64'(walk_req_addr), 64'(exp_q[0]));
    chk("merge_ack", 64'(miss_ack), 64'h24);
    exp_q.push_back(51'h1234);
    tick();

    // cycle 18
    miss_valid = 6'b001000;
    #4;
    chk("retry_ack", 64'(miss_ack), 64'h08);
    exp_q.push_back(51'h2000);
    tick();

    // cycle 19
    miss_addr[1] = 51'h3000;
    miss_valid   = 6'b000010;
    #4;
    chk("count_3", 64'(dbg_mq_count), 64'h3);
    chk("fourth_ack", 64'(miss_ack), 64'h02);
    exp_q.push_back(51'h3000);
    tick();

    // cycle 20: queue full, distinct miss refused, pair of entry 1 merged
    miss_addr[4] = 51'h4000;
    miss_addr[0] = 51'h1235;
    miss_valid   = 6'b010001;
    #4;
    chk("count_full", 64'(dbg_mq_count), 64'h4);
    chk("full_ack", 64'(miss_ack), 64'h01);
    chk("req_hold_valid", 64'(walk_req_valid), 64'h1);
    chk("req_hold_addr", 64'(walk_req_addr), 64'(exp_q[0]));
    tick();

    // cycle 21
    miss_valid     = '0;
    walk_req_ready = 1'b1;
    #4;
    req_handshake();
    tick();

    // cycle 22: WWAIT, full invalidation must wait, response arrives
    walk_req_ready = 1'b0;
    inv_valid      = 1'b1;
    inv_all        = 1'b1;
    walk_rsp_valid = 1'b1;
    walk_rsp_data0 = 64'hA;
    walk_rsp_data1 = 64'hB;
    walk_rsp_data2 = 64'hC;
    exp_data_q.push_back(64'hA);
    exp_data_q.push_back(64'hB);
    exp_data_q.push_back(64'hC);
    #4;
    chk("inv_hold_wwait", 64'(inv_ready), 64'h0);
    chk("wwait_req_valid", 64'(walk_req_valid), 64'h0);
    tick();

    // cycle 23: FILL, with a push into the full queue alongside the pop
    walk_rsp_valid = 1'b0;
    miss_valid     = 6'b010000;
    #4;
    chk("fill_wen", 64'(tlb_write_wen), 64'h1);
    chk("fill_xstant", 64'(tlb_write_xstant), 64'h0);
    chk("fill_invl", 64'(tlb_write_invl), 64'h0);
    chk("fill_fwe", 64'(tlb_force_way_en), 64'h0);
    chk("fill_addr", 64'(tlb_write_addr), 64'h1000);
    fill_check();
    chk("inv_hold_fill", 64'(inv_ready), 64'h0);
    chk("pop_push_ack", 64'(miss_ack), 64'h10);
    exp_q.push_back(51'h4000);
    tick();

    // cycle 24: IDLE takes the invalidation first
    miss_valid = '0;
    #4;
    chk("count_after_fill", 64'(dbg_mq_count), 64'h4);
    chk("inv_ready_idle", 64'(inv_ready), 64'h1);
    chk("idle_wen", 64'(tlb_write_wen), 64'h0);
    tick();

    // cycles 25..152: sweep
    inv_valid = 1'b0;
    inv_all   = 1'b0;
    for (int k = 0; k < DTLB_SETS * DTLB_WAYS; k++) begin
      #4;
      chk("sweep_way", 64'(tlb_force_way), 64'(k % DTLB_WAYS));
      chk("sweep_set", 64'(tlb_write_addr), 64'(k / DTLB_WAYS));
      chk("sweep_ctl", 64'({tlb_write_wen, tlb_write_xstant, tlb_write_invl, tlb_force_way_en}), 64'hF);
      tick();
    end

    // cycle 153
    #4;
    chk("post_sweep_state", 64'(dbg_state), 64'(IDLE));
    chk("post_sweep_wen", 64'(tlb_write_wen), 64'h0);
    chk("post_sweep_fwe", 64'(tlb_force_way_en), 64'h0);
    tick();

    // cycle 154
    walk_req_ready = 1'b1;
    #4;
    req_handshake();
    tick();

    // cycle 155: faulting response
    walk_req_ready = 1'b0;
    walk_rsp_valid = 1'b1;
    walk_rsp_fault = 1'b1;
    walk_rsp_data0 = 64'h77;
    #4;
    tick();

    // cycle 156: fault pulse, single invalidation requested
    walk_rsp_valid = 1'b0;
    walk_rsp_fault = 1'b0;
    inv_valid      = 1'b1;
    inv_addr       = 51'h5555;
    #4;
    chk("fault_valid", 64'(fault_valid), 64'h1);
    chk("fault_addr", 64'(fault_addr), 64'h1234);
    chk("fault_no_wen", 64'(tlb_write_wen), 64'h0);
    chk("count_after_fault", 64'(dbg_mq_count), 64'h3);
    chk("inv_ready_single", 64'(inv_ready), 64'h1);
    tick();

    // cycle 157: INV_STEAL
    inv_valid = 1'b0;
    #4;
    chk("steal_1", 64'(port0_steal), 64'h1);
    chk("steal_addr", 64'(tlb_write_addr), 64'h5555);
    chk("steal_wen", 64'(tlb_write_wen), 64'h0);
    chk("fault_pulse_end", 64'(fault_valid), 64'h0);
    tick();

    // cycle 158: INV_WR
    #4;
    chk("steal_2", 64'(port0_steal), 64'h1);
    chk("inv_wr_ctl", 64'({tlb_write_wen, tlb_write_xstant, tlb_write_invl, tlb_force_way_en}), 64'hE);
    chk("inv_wr_addr", 64'(tlb_write_addr), 64'h5555);
    tick();

    // cycle 159
    #4;
    chk("inv_done_steal", 64'(port0_steal), 64'h0);
    chk("inv_done_wen", 64'(tlb_write_wen), 64'h0);
    chk("inv_done_state", 64'(dbg_state), 64'(IDLE));
    tick();

    // cycle 160
    walk_req_ready = 1'b1;
    #4;
    req_handshake();
    tick();

    // cycle 161: reset during WWAIT with a response on the wires
    walk_req_ready = 1'b0;
    rst            = 1'b1;
    walk_rsp_valid = 1'b1;
    walk_rsp_fault = 1'b1;
    miss_valid     = 6'b000001;
    #4;
    chk("mid_rst_state", 64'(dbg_state), 64'(RST_WAIT));
    chk("mid_rst_count", 64'(dbg_mq_count), 64'h0);
    chk("mid_rst_ack", 64'(miss_ack), 64'h0);
    chk("mid_rst_fault", 64'(fault_valid), 64'h0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #4;
      chk("drop_rsp_fault", 64'(fault_valid), 64'h0);
      chk("drop_rsp_wen", 64'(tlb_write_wen), 64'h0);
      tick();
    end
    walk_rsp_valid = 1'b0;
    walk_rsp_fault = 1'b0;
    miss_valid     = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
